// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS bench data-memory model.
package mips_mem_pkg;

  typedef enum logic [1:0] {StInit, StIdle, StWait} state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [WORD_BYTES-1:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_mem_init_seq.sv
// Post-reset preload sequencer: walks an arithmetic series into words 0..INIT_COUNT-1.
module mips_mem_init_seq
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned INIT_COUNT  = 30,
  parameter logic [31:0] INIT_START  = 32'h1234_5678,
  parameter logic [31:0] INIT_STEP   = 32'hDCBA_1234,
  parameter bit          ENDIAN_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] init_addr,
  output logic [31:0]       init_data,
  output logic              init_we,
  output logic              init_last,
  output logic              init_done
);

  logic [31:0] idx_q;
  logic [31:0] acc_q;
  logic        done_q;

  // Also true with INIT_COUNT=0, so the sequencer finishes after one cycle.
  assign init_last = !done_q && ((idx_q + 32'd1) >= INIT_COUNT);
  assign init_we   = !done_q && (idx_q < INIT_COUNT);
  assign init_addr = idx_q[ADDR_W-1:0];
  assign init_data = ENDIAN_SWAP ? byteswap32(acc_q) : acc_q;
  assign init_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 32'd0;
      acc_q  <= INIT_START;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (init_last) begin
        done_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 32'd1;
        acc_q <= acc_q + INIT_STEP;
      end
    end
  end

endmodule

// File: rtl/mips_data_ram_ctrl.sv
// Parametrised data RAM with byte enables, base address, wait states and reset preload.
module mips_data_ram_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned INIT_COUNT  = 30,
  parameter logic [31:0] INIT_START  = 32'h1234_5678,
  parameter logic [31:0] INIT_STEP   = 32'hDCBA_1234,
  parameter bit          ENDIAN_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic        data_err,
  output logic        init_done
);

  localparam int unsigned ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        err_q;

  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       init_data;
  logic              init_we;
  logic              init_last;

  logic [31:0]       offset;
  logic [31:0]       word_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              in_range;
  logic              req;
  logic              accept;

  mips_mem_init_seq #(
    .ADDR_W      (ADDR_W),
    .INIT_COUNT  (INIT_COUNT),
    .INIT_START  (INIT_START),
    .INIT_STEP   (INIT_STEP),
    .ENDIAN_SWAP (ENDIAN_SWAP)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_we   (init_we),
    .init_last (init_last),
    .init_done (init_done)
  );

  // A subtraction wrap is caught by the explicit below-base compare.
  assign offset   = data_address - BASE_ADDR;
  assign word_off = offset >> 2;
  assign in_range = (data_address >= BASE_ADDR) && (word_off < DEPTH_WORDS);
  assign ram_idx  = word_off[ADDR_W-1:0];
  assign req      = data_read | data_write;
  assign data_err = err_q;

  always_comb begin
    accept           = 1'b0;
    data_waitrequest = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!req) begin
          data_waitrequest = 1'b0;
        end else if (WAIT_CYCLES == 0) begin
          accept           = 1'b1;
          data_waitrequest = 1'b0;
        end
      end
      StWait: begin
        if (!req) begin
          data_waitrequest = 1'b0;
        end else if (cnt_q == 4'd0) begin
          accept           = 1'b1;
          data_waitrequest = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign data_readdata = (accept && data_read && in_range) ? mem[ram_idx] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      unique case (state_q)
        StInit: if (init_last) state_q <= StIdle;
        StIdle: begin
          if (req && (WAIT_CYCLES != 0)) begin
            cnt_q   <= WAIT_LOAD;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!req || (cnt_q == 4'd0)) state_q <= StIdle;
          else                         cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Preload and accesses never overlap: accepts only happen outside StInit.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (accept && data_write && in_range) begin
      mem[ram_idx] <= be_merge(mem[ram_idx], data_writedata, data_byteenable);
    end
  end

endmodule

// File: tb/tb_mips_data_ram_ctrl.sv
// Directed scoreboard bench for mips_data_ram_ctrl over four parameter sets.
module tb_mips_data_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic [31:0] data_address, data_writedata;
  logic        data_read, data_write;
  logic [3:0]  data_byteenable;

  logic [31:0] rdata [4];
  logic        wreq  [4];
  logic        err   [4];
  logic        done  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  mips_data_ram_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_byteenable(data_byteenable),
    .data_writedata(data_writedata), .data_readdata(rdata[0]),
    .data_waitrequest(wreq[0]), .data_err(err[0]), .init_done(done[0])
  );

  mips_data_ram_ctrl #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_byteenable(data_byteenable),
    .data_writedata(data_writedata), .data_readdata(rdata[1]),
    .data_waitrequest(wreq[1]), .data_err(err[1]), .init_done(done[1])
  );

  mips_data_ram_ctrl #(.BASE_ADDR(32'h1000_0000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_byteenable(data_byteenable),
    .data_writedata(data_writedata), .data_readdata(rdata[2]),
    .data_waitrequest(wreq[2]), .data_err(err[2]), .init_done(done[2])
  );

  mips_data_ram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_byteenable(data_byteenable),
    .data_writedata(data_writedata), .data_readdata(rdata[3]),
    .data_waitrequest(wreq[3]), .data_err(err[3]), .init_done(done[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed %h expected queued entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // One access on instance k, started at posedge+2 and ending at posedge+2.
  task automatic run(input int k, input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input int exp_waits, input logic exp_err);
    int          waits;
    logic [31:0] rv;
    logic        e1;
    push("rdata", exp_rd);
    push("waits", 32'(exp_waits));
    push("err_pulse", {31'd0, exp_err});
    data_address    = addr;
    data_read       = rd;
    data_write      = wr;
    data_byteenable = be;
    data_writedata  = wd;
    waits = 0;
    #1;
    while (wreq[k] && waits < 20) begin
      chk("rdata_zero_in_wait", rdata[k], 32'd0);
      @(posedge clk);
      #2;
      waits++;
    end
    rv = rdata[k];
    @(posedge clk);
    #1;
    e1         = err[k];
    data_read  = 1'b0;
    data_write = 1'b0;
    #1;
    chk("rdata_zero_idle", rdata[k], 32'd0);
    chk("wreq_idle", 32'(wreq[k]), 32'd0);
    pop_chk(rv);
    pop_chk(32'(waits));
    pop_chk({31'd0, e1});
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err[k]), 32'd0);
    #1;
  endtask

  initial begin
    int   n;
    logic saw_ready;
    rst_n = 1'b0;
    rst3_n = 1'b0;
    data_address = 32'd0;
    data_read = 1'b0;
    data_write = 1'b0;
    data_byteenable = 4'h0;
    data_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wreq", 32'(wreq[0]), 32'd1);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);

    // Write held through preload must be ignored.
    rst_n = 1'b1;
    rst3_n = 1'b1;
    data_address = 32'd0;
    data_write = 1'b1;
    data_byteenable = 4'hF;
    data_writedata = 32'd0;
    n = 0;
    saw_ready = 1'b0;
    while (!done[0] && n < 100) begin
      if (!wreq[0]) saw_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    data_write = 1'b0;
    #1;
    chk("init_edges", 32'(n), 32'd30);
    chk("wreq_during_init", 32'(saw_ready), 32'd0);

    run(0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h7856_3412, 0, 1'b0);
    run(0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'hAC68_EEEE, 0, 1'b0);
    run(0, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 32'hE07A_A8CB, 0, 1'b0);
    run(0, 32'h8, 1'b0, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
    run(0, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 32'hE0BB_A8DD, 0, 1'b0);
    run(0, 32'hC, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h148D_62A8, 0, 1'b0);
    run(0, 32'hC, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
    run(0, 32'h4000, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b1);
    run(0, 32'h4000, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 0, 1'b1);
    run(0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h7856_3412, 0, 1'b0);
    run(0, 32'h3FFC, 1'b0, 1'b1, 4'hF, 32'h5A5A_1234, 32'h0, 0, 1'b0);
    run(0, 32'h3FFC, 1'b1, 1'b0, 4'h0, 32'h0, 32'h5A5A_1234, 0, 1'b0);

    run(1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 32'hAC68_EEEE, 2, 1'b0);

    run(2, 32'h0FFF_FFFC, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b1);
    run(2, 32'h1000_0004, 1'b1, 1'b0, 4'h0, 32'h0, 32'hAC68_EEEE, 0, 1'b0);

    // Reset lands while the write is still in wait states.
    data_address = 32'h0;
    data_write = 1'b1;
    data_byteenable = 4'hF;
    data_writedata = 32'h0;
    #1;
    chk("rst3_wreq_cycle0", 32'(wreq[3]), 32'd1);
    @(posedge clk);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("rst3_wreq_async", 32'(wreq[3]), 32'd1);
    chk("rst3_done_low", 32'(done[3]), 32'd0);
    data_write = 1'b0;
    @(posedge clk);
    #2;
    rst3_n = 1'b1;
    n = 0;
    while (!done[3] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    #1;
    chk("rst3_init_edges", 32'(n), 32'd30);
    run(3, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h7856_3412, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_data_ram_ctrl.md
Name: mips_data_ram_ctrl

Overview:
Parametrised data-memory model for the MIPS core test benches. It replaces the fixed 4096-word, combinational, preloaded data RAMs used in earlier benches. Adds byte-enable writes, a configurable base address and depth, and a waitrequest handshake with programmable wait states. It also has a reset-driven initialisation sequencer that writes an arithmetic series into the RAM, so tests get the same preload without duplicated initial blocks.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_CYCLES, 0, wait states inserted before each access is accepted (0..15)
INIT_COUNT, 30, words preloaded after reset (0..DEPTH_WORDS)
INIT_START, 32'h1234_5678, first series value
INIT_STEP, 32'hDCBA_1234, series difference (mod 2^32)
ENDIAN_SWAP, 1, byte-reverse series values before storing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_address  in  32  byte address; bits [1:0] ignored
data_read  in  1  read request
data_write  in  1  write request
data_byteenable  in  4  write lane enables; bit0 -> [7:0]
data_writedata  in  32  write data
data_readdata  out  32  read data
data_waitrequest  out  1  high = request not accepted this cycle
data_err  out  1  one-cycle pulse on an accepted out-of-range access
init_done  out  1  high once preload completes

Behaviour:
- Reset (rst_n low, async):
  - state=INIT, init index=0, wait counter=0.
  - init_done=0, data_waitrequest=1, data_err=0, data_readdata=0.
  - RAM contents are not cleared.
- States and transitions:
  - INIT:
    - One word per clk: word[idx] = ENDIAN_SWAP ? byteswap(INIT_START+INIT_STEP*idx) : same value unswapped.
    - After INIT_COUNT writes -> IDLE. INIT_COUNT=0 -> IDLE after one cycle.
    - data_waitrequest=1 throughout; requests are ignored.
  - IDLE, no request: data_waitrequest=0.
  - IDLE, request, WAIT_CYCLES=0: access accepted this cycle.
  - IDLE, request, WAIT_CYCLES>0: data_waitrequest=1, cnt=WAIT_CYCLES-1, -> WAIT.
  - WAIT, cnt!=0: data_waitrequest=1, cnt decrements.
  - WAIT, cnt=0: access accepted, data_waitrequest=0, -> IDLE.
  - Total request latency = WAIT_CYCLES+1 cycles.
- Accepted access:
  - Read: data_readdata = word, combinational in the accept cycle.
  - Write: enabled bytes written at the accept-cycle clk edge.
  - data_readdata=0 in every non-accept cycle.
- Master rules and aborts:
  - Master holds address, data and controls stable while data_waitrequest=1.
  - Request dropped in WAIT: abort -> IDLE, no write, no err.
- Simultaneous read+write: the write is performed and data_readdata returns the pre-write word.
- Addressing:
  - index = (data_address - BASE_ADDR) >> 2.
  - Out of range (address < BASE_ADDR or index >= DEPTH_WORDS): write suppressed, readdata=0, data_err=1 registered for the cycle after accept.
  - Index arithmetic is 32-bit unsigned; subtraction wrap counts as out of range.
- Reset mid-operation: pending access dropped, no partial write, preload re-runs and overwrites words 0..INIT_COUNT-1.
- Words at or above INIT_COUNT keep power-up values (X in sim) until written.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum {INIT, IDLE, WAIT}
  - WORD_BYTES=4
  - byteswap32 function
  - byte-enable merge function
- One sub-module, mips_mem_init_seq: the index counter and series accumulator (adds INIT_STEP each cycle, no multiplier), outputting address, data, write strobe and done.

Test Plan:
- Defaults, release reset -> init_done rises exactly 30 clk edges later; data_waitrequest=1 until then. Read 0x0 -> 0x78563412; read 0x4 -> 0xAC68EEEE in the same cycle.
- Write 0xAABBCCDD to 0x8 with byteenable 4'b0101 (word holds 0xE07AA8CB) -> read 0x8 returns 0xE0BBA8DD.
- WAIT_CYCLES=2, read 0x4 held from cycle 0 -> waitrequest 1,1,0 on cycles 0..2; readdata 0xAC68EEEE only in cycle 2, 0 in cycles 0-1.
- Read 0x4000 with DEPTH_WORDS=4096 -> readdata 0, data_err pulses one cycle. Write 0x4000 -> no RAM word changes.
- BASE_ADDR=32'h1000_0000: read 0x0FFF_FFFC -> data_err=1; read 0x1000_0004 -> 0xAC68EEEE.
- WAIT_CYCLES=3: write 0 to 0x0 and assert rst_n low in cycle 1 -> data_waitrequest=1 at once. After re-init, read 0x0 -> 0x78563412 (write dropped).
